ped_request_unit: RTL and testbench

- Pedestrian-side front end for the intersection controller. Drives the controller's pedestrian_req input and consumes its ped_green/ped_red outputs, closing the crossing handshake from the pushbutton side.
- Synchronises and debounces the raw crosswalk button and latches a press into a held request until the controller grants the walk.
- Drives the "WAIT" lamp and the walk countdown display, and enforces a post-walk lockout.

---
 rtl/ped_pkg.sv | 24 ++
 rtl/ped_debounce.sv | 48 ++++
 rtl/ped_request_unit.sv | 139 +++++++++++++
 tb/tb_ped_request_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian request front end.
// The state encoding is fixed at 2 bits so it can be probed on a debug bus.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        WALK    = 2'd2,
        LOCKOUT = 2'd3
    } ped_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_WALK_CYCLES     = 10;
    localparam int DEF_LOCKOUT_CYCLES  = 8;
    localparam int DEF_MAX_WAIT_CYCLES = 200;
    localparam int DEF_CNT_W           = 8;

    localparam int WAIT_W = 16;

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == {WAIT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// Two-flop synchroniser and level debouncer for the crosswalk button.
// o_press is a one-cycle pulse on the edge where the debounced level rises.
module ped_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button_raw,
    output logic o_press
);

    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;
    logic            w_differs;
    logic            w_flip;

    assign w_differs = (r_sync2 != r_level);
    assign w_flip    = w_differs && (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    // Pulse is taken before the level register updates so the FSM reacts on the accepting edge.
    assign o_press   = w_flip && r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_button_raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian-side request FSM: latches presses into a held request, drives the
// wait lamp and walk countdown, and enforces the post-walk lockout.
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int MAX_WAIT_CYCLES = DEF_MAX_WAIT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_button_raw,
    input  logic             i_ped_green,
    input  logic             i_ped_red,
    input  logic             i_emergency,
    output logic             o_pedestrian_req,
    output logic             o_wait_lamp,
    output logic             o_walk_active,
    output logic [CNT_W-1:0] o_walk_countdown,
    output logic             o_wait_timeout,
    output logic             o_proto_err
);

    localparam int LOCK_W = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

    ped_state_e        r_state;
    logic              r_pending;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_req;
    logic              r_lamp;
    logic              r_walk;
    logic [CNT_W-1:0]  r_countdown;
    logic              r_timeout;
    logic              r_proto_err;
    logic              w_press;
    logic [WAIT_W-1:0] w_wait_inc;

    ped_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_button_raw (i_button_raw),
        .o_press      (w_press)
    );

    assign w_wait_inc = sat_inc_wait(r_wait_cnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_wait_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_req       <= 1'b0;
            r_lamp      <= 1'b0;
            r_walk      <= 1'b0;
            r_countdown <= '0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | (i_ped_green == i_ped_red);
            r_req       <= 1'b0;
            r_lamp      <= 1'b0;
            r_walk      <= 1'b0;
            r_countdown <= '0;

            // A grant seen from any non-walk state wins over every other event.
            if (i_ped_green && (r_state != WALK)) begin
                r_state     <= WALK;
                r_walk      <= 1'b1;
                r_countdown <= CNT_W'(WALK_CYCLES);
                r_pending   <= 1'b0;
                r_timeout   <= 1'b0;
                r_wait_cnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press) begin
                            r_state   <= WAITING;
                            r_pending <= 1'b1;
                            r_req     <= ~i_emergency;
                            r_lamp    <= 1'b1;
                        end
                    end
                    WAITING: begin
                        r_req  <= ~i_emergency;
                        r_lamp <= 1'b1;
                        if (!i_emergency) begin
                            r_wait_cnt <= w_wait_inc;
                            if (w_wait_inc > WAIT_W'(MAX_WAIT_CYCLES)) begin
                                r_timeout <= 1'b1;
                            end
                        end
                    end
                    WALK: begin
                        if (i_ped_green) begin
                            r_walk      <= 1'b1;
                            r_countdown <= (r_countdown == '0) ? '0 : r_countdown - 1'b1;
                        end else begin
                            r_state    <= LOCKOUT;
                            r_lock_cnt <= LOCK_W'(LOCKOUT_CYCLES - 1);
                        end
                    end
                    LOCKOUT: begin
                        if (r_lock_cnt == '0) begin
                            if (r_pending || w_press) begin
                                r_state   <= WAITING;
                                r_pending <= 1'b1;
                                r_req     <= ~i_emergency;
                                r_lamp    <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_lock_cnt <= r_lock_cnt - 1'b1;
                            if (w_press) begin
                                r_pending <= 1'b1;
                            end
                            r_lamp <= r_pending | w_press;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_pedestrian_req = r_req;
    assign o_wait_lamp      = r_lamp;
    assign o_walk_active    = r_walk;
    assign o_walk_countdown = r_countdown;
    assign o_wait_timeout   = r_timeout;
    assign o_proto_err      = r_proto_err;

endmodule

// File: tb/tb_ped_request_unit.sv
// Self-checking bench for ped_request_unit: vector table, directed corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_ped_request_unit;

    localparam int D     = 4;
    localparam int WALKC = 10;
    localparam int LOCKC = 8;
    localparam int MAXW  = 200;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn;
    logic          green;
    logic          red;
    logic          emg;
    logic          req;
    logic          lamp;
    logic          walk;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic          perr;

    int n_tests = 0;
    int n_fail  = 0;

    ped_request_unit #(
        .DEBOUNCE_CYCLES (D),
        .WALK_CYCLES     (WALKC),
        .LOCKOUT_CYCLES  (LOCKC),
        .MAX_WAIT_CYCLES (MAXW),
        .CNT_W           (CW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_button_raw     (btn),
        .i_ped_green      (green),
        .i_ped_red        (red),
        .i_emergency      (emg),
        .o_pedestrian_req (req),
        .o_wait_lamp      (lamp),
        .o_walk_active    (walk),
        .o_walk_countdown (cnt),
        .o_wait_timeout   (tmo),
        .o_proto_err      (perr)
    );

    always #5 clk = ~clk;

    // Reference model: button history, phase name, pending flag, wait count, lockout cycles left.
    localparam int P_IDLE = 0, P_WAIT = 1, P_WALK = 2, P_LOCK = 3;
    bit m_hist[$];
    bit m_lvl;
    int m_phase;
    bit m_pending;
    int m_wait;
    int m_lock_left;
    int m_cnt;
    bit m_tmo;
    bit m_perr;
    bit m_req;
    bit m_lamp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int k = 0; k < D + 2; k++) m_hist.push_back(1'b0);
        m_lvl = 0; m_phase = P_IDLE; m_pending = 0; m_wait = 0; m_lock_left = 0;
        m_cnt = 0; m_tmo = 0; m_perr = 0; m_req = 0; m_lamp = 0;
    endtask

    task automatic model_step(input bit b, input bit g, input bit r, input bit e);
        bit all_diff;
        bit press;
        // The debouncer at this edge sees the button as it was two edges ago;
        // it accepts a change once the last D such samples all disagree with the level.
        m_hist.push_front(b);
        all_diff = 1;
        for (int k = 2; k <= D + 1; k++) if (m_hist[k] == m_lvl) all_diff = 0;
        void'(m_hist.pop_back());
        press = 0;
        if (all_diff) begin
            m_lvl = !m_lvl;
            press = m_lvl;
        end
        if (g == r) m_perr = 1;
        if (g && m_phase != P_WALK) begin
            m_phase = P_WALK; m_cnt = WALKC; m_pending = 0; m_tmo = 0; m_wait = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (press) begin m_phase = P_WAIT; m_pending = 1; end
                P_WAIT: if (!e) begin
                    if (m_wait < 65535) m_wait++;
                    if (m_wait > MAXW) m_tmo = 1;
                end
                P_WALK: if (g) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
                        else begin m_phase = P_LOCK; m_lock_left = LOCKC; m_cnt = 0; end
                default: begin
                    if (press) m_pending = 1;
                    m_lock_left--;
                    if (m_lock_left == 0) m_phase = m_pending ? P_WAIT : P_IDLE;
                end
            endcase
        end
        m_req  = (m_phase == P_WAIT) && !e;
        m_lamp = (m_phase == P_WAIT) || (m_phase == P_LOCK && m_pending);
        if (m_phase != P_WALK) m_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(btn, green, red, emg);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = 1'b0; green = 1'b0; red = 1'b1; emg = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit btn, grn;
        bit req, lamp, walk;
        int cnt;
    } vec_t;
    vec_t tbl[34];

    initial begin
        int edge_n;
        int k;
        // Clean press then a held grant: edge n applies row n-1.
        for (int i = 0; i < 34; i++) begin
            edge_n = i + 1;
            tbl[i].btn  = (edge_n <= 10);
            tbl[i].grn  = (edge_n >= 20 && edge_n <= 31);
            tbl[i].req  = (edge_n >= 6 && edge_n < 20);
            tbl[i].lamp = tbl[i].req;
            tbl[i].walk = tbl[i].grn;
            tbl[i].cnt  = tbl[i].walk ? ((WALKC - (edge_n - 20) > 0) ? WALKC - (edge_n - 20) : 0) : 0;
        end

        do_reset();
        check("rst_req", req, 0);
        check("rst_lamp", lamp, 0);
        check("rst_walk", walk, 0);
        check("rst_cnt", cnt, 0);
        check("rst_tmo", tmo, 0);
        check("rst_perr", perr, 0);

        foreach (tbl[i]) begin
            btn = tbl[i].btn; green = tbl[i].grn; red = !tbl[i].grn;
            tick();
            check($sformatf("tbl_req[%0d]", i), req, tbl[i].req);
            check($sformatf("tbl_lamp[%0d]", i), lamp, tbl[i].lamp);
            check($sformatf("tbl_walk[%0d]", i), walk, tbl[i].walk);
            check($sformatf("tbl_cnt[%0d]", i), cnt, tbl[i].cnt);
        end

        // Bounce shorter than the debounce window must never raise a request.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            btn = (i < 6) ? ((i % 2) == 0) : 1'b0;
            tick();
            check("bounce_req", req, 0);
        end
        check("bounce_lamp", lamp, 0);

        // Emergency hold inside WAITING, then timeout with the frozen timer.
        do_reset();
        btn = 1'b1;
        k = 0;
        while (!req && k < 20) begin tick(); k++; end
        check("wait_entry", req, 1);
        btn = 1'b0;
        repeat (3) tick();
        check("pre_emg_req", req, 1);
        emg = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("emg_req", req, 0);
            check("emg_lamp", lamp, 1);
        end
        emg = 1'b0;
        tick();
        check("post_emg_req", req, 1);
        // 7 edges elapsed since entry, 3 frozen: timer now 4; it reaches 201 at 204 elapsed.
        repeat (203 - 7) tick();
        check("tmo_before", tmo, 0);
        tick();
        check("tmo_set", tmo, 1);
        repeat (5) tick();
        check("tmo_sticky", tmo, 1);
        green = 1'b1; red = 1'b0;
        tick();
        check("grant_tmo_clr", tmo, 0);
        check("grant_req_drop", req, 0);
        check("grant_walk", walk, 1);
        check("grant_cnt", cnt, WALKC);

        // Press during lockout: request comes straight back on the lockout exit edge.
        repeat (2) tick();
        green = 1'b0; red = 1'b1;
        tick();
        check("lock_walk", walk, 0);
        check("lock_cnt", cnt, 0);
        btn = 1'b1;
        repeat (6) tick();
        check("lock_pending_lamp", lamp, 1);
        tick();
        check("lock_req_held", req, 0);
        tick();
        check("lock_exit_req", req, 1);
        check("lock_exit_lamp", lamp, 1);
        btn = 1'b0;
        repeat (10) tick();

        // Plain lockout with no press ends idle.
        green = 1'b1; red = 1'b0;
        tick();
        green = 1'b0; red = 1'b1;
        repeat (LOCKC + 2) tick();
        check("lock_idle_req", req, 0);
        check("lock_idle_lamp", lamp, 0);

        // Asynchronous reset in the middle of WAITING.
        do_reset();
        btn = 1'b1;
        repeat (8) tick();
        check("pre_rst_req", req, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", req, 0);
        check("async_rst_lamp", lamp, 0);
        btn = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();
        check("post_rst_req", req, 0);

        // Protocol error is sticky until reset.
        green = 1'b1; red = 1'b1;
        tick();
        check("perr_set", perr, 1);
        green = 1'b0;
        repeat (4) tick();
        check("perr_sticky", perr, 1);
        do_reset();
        check("perr_clr", perr, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn = !btn;
            if ($urandom_range(0, 24) == 0) green = !green;
            red = !green;
            if ($urandom_range(0, 1999) == 0) red = green;
            if ($urandom_range(0, 15) == 0) emg = !emg;
            tick();
            check($sformatf("rand[%0d] {req,lamp,walk,tmo,perr,cnt}", i),
                  {req, lamp, walk, tmo, perr, cnt},
                  {m_req, m_lamp, m_phase == P_WALK, m_tmo, m_perr, 8'(m_cnt)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
